// File: rtl/cache_controller_pkg.sv
// Shared constants for the cache controller: field widths, address slicing
// and the FSM state encoding.
package cache_controller_pkg;

  // Field widths of the tag, data word and word-within-block selector.
  localparam int TAG_W  = 5;
  localparam int DATA_W = 16;
  localparam int WORD_W = 2;

  // Address layout is {tag, index, word}. The word field sits at bit 0 and
  // the index follows it. The tag position depends on the index width, so
  // the controller derives it locally.
  localparam int WORD_LSB  = 0;
  localparam int INDEX_LSB = WORD_LSB + WORD_W;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COMP    = 3'd1;
  localparam logic [2:0] ST_GAP     = 3'd2;
  localparam logic [2:0] ST_WB_RD   = 3'd3;
  localparam logic [2:0] ST_WB_WR   = 3'd4;
  localparam logic [2:0] ST_FILL_RD = 3'd5;
  localparam logic [2:0] ST_FILL_WR = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

endpackage

// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped cache. The tag
// and data set and the backing memory are both external; this block only
// sequences them.
// A miss first writes back a dirty victim one word at a time. It then fills
// the block one word at a time and re-runs the compare, which now hits.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int INDEX_W = 3,
  parameter int WORDS   = 4,
  parameter int ADDR_W  = 5 + INDEX_W + 2
) (
  input  logic                clk,
  input  logic                rst,
  // CPU side
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_done,
  output logic                cpu_hit,
  // Cache set command
  output logic                set_en,
  output logic [INDEX_W-1:0]  set_sel,
  output logic [WORD_W-1:0]   set_word,
  output logic                set_comp,
  output logic                set_write,
  output logic                set_valid,
  output logic [TAG_W-1:0]    set_tag,
  output logic [DATA_W-1:0]   set_data,
  // Cache set response
  input  logic                set_hit,
  input  logic                set_dirty,
  input  logic                set_valid_out,
  input  logic                set_ack,
  input  logic [TAG_W-1:0]    set_tag_out,
  input  logic [DATA_W-1:0]   set_data_out,
  // Backing memory
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int TAG_LSB = INDEX_LSB + INDEX_W;
  localparam logic [WORD_W-1:0] K_LAST = WORD_W'(WORDS - 1);

  logic [2:0]         state_q, state_d;
  logic [2:0]         gap_next_q, gap_next_d;   // state entered after GAP
  logic [WORD_W-1:0]  k_q, k_d;                 // word counter for WB/fill
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               first_cmp_q, first_cmp_d; // first compare already seen
  logic               hit_q, hit_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;       // tag of the victim line
  logic [DATA_W-1:0]  buf_q, buf_d;             // word in transit

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [WORD_W-1:0]  req_word;
  logic               k_last;

  assign req_tag  = addr_q[TAG_LSB +: TAG_W];
  assign req_idx  = addr_q[INDEX_LSB +: INDEX_W];
  assign req_word = addr_q[WORD_LSB +: WORD_W];
  assign k_last   = (k_q == K_LAST);

  // Next-state logic: the request sequence and the capture of set/memory responses
  always_comb begin
    state_d     = state_q;
    gap_next_d  = gap_next_q;
    k_d         = k_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    first_cmp_d = first_cmp_q;
    hit_d       = hit_q;
    rdata_d     = rdata_q;
    wb_tag_d    = wb_tag_q;
    buf_d       = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d        = cpu_we;
          addr_d      = cpu_addr;
          wdata_d     = cpu_wdata;
          first_cmp_d = 1'b0;
          state_d     = ST_COMP;
        end
      end
      ST_COMP: begin
        if (set_ack) begin
          first_cmp_d = 1'b1;
          // Only the very first compare decides cpu_hit; the retry after a fill always hits.
          if (!first_cmp_q) hit_d = set_hit;
          if (set_hit) begin
            if (!we_q) rdata_d = set_data_out;
            state_d = ST_DONE;
          end else begin
            k_d        = '0;
            state_d    = ST_GAP;
            gap_next_d = (set_valid_out && set_dirty) ? ST_WB_RD : ST_FILL_RD;
          end
        end
      end
      ST_GAP: begin
        state_d = gap_next_q;
      end
      ST_WB_RD: begin
        if (set_ack) begin
          wb_tag_d   = set_tag_out;
          buf_d      = set_data_out;
          state_d    = ST_GAP;
          gap_next_d = ST_WB_WR;
        end
      end
      ST_WB_WR: begin
        if (mem_ack) begin
          state_d = ST_GAP;
          if (k_last) begin
            k_d        = '0;
            gap_next_d = ST_FILL_RD;
          end else begin
            k_d        = k_q + 1'b1;
            gap_next_d = ST_WB_RD;
          end
        end
      end
      ST_FILL_RD: begin
        if (mem_ack) begin
          buf_d   = mem_rdata;
          state_d = ST_FILL_WR;
        end
      end
      ST_FILL_WR: begin
        if (set_ack) begin
          state_d = ST_GAP;
          if (k_last) begin
            k_d        = '0;
            gap_next_d = ST_COMP;
          end else begin
            k_d        = k_q + 1'b1;
            gap_next_d = ST_FILL_RD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gap_next_q  <= ST_IDLE;
      k_q         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      first_cmp_q <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      wb_tag_q    <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      gap_next_q  <= gap_next_d;
      k_q         <= k_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      first_cmp_q <= first_cmp_d;
      hit_q       <= hit_d;
      rdata_q     <= rdata_d;
      wb_tag_q    <= wb_tag_d;
      buf_q       <= buf_d;
    end
  end

  // Command outputs are pure functions of registered state, so they hold steady until the ack
  always_comb begin
    set_en    = 1'b0;
    set_sel   = req_idx;
    set_word  = k_q;
    set_comp  = 1'b0;
    set_write = 1'b0;
    set_valid = 1'b0;
    set_tag   = req_tag;
    set_data  = buf_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {req_tag, req_idx, k_q};
    mem_wdata = buf_q;
    case (state_q)
      ST_COMP: begin
        set_en    = 1'b1;
        set_comp  = 1'b1;
        set_write = we_q;
        set_word  = req_word;
        set_data  = wdata_q;
      end
      ST_WB_RD: begin
        set_en = 1'b1;
      end
      ST_FILL_WR: begin
        set_en    = 1'b1;
        set_write = 1'b1;
        set_valid = 1'b1;
      end
      ST_WB_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {wb_tag_q, req_idx, k_q};
      end
      ST_FILL_RD: begin
        mem_req = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cpu_done  = (state_q == ST_DONE);
  assign cpu_hit   = hit_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller. It models the external set and memory, drives
// directed and random CPU requests, and checks every completion against a
// flat-memory reference model.
module tb_cache_controller;

  localparam int IW = 3;
  localparam int AW = 5 + IW + 2;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic cpu_done, cpu_hit;
  logic set_en;
  logic [IW-1:0] set_sel;
  logic [1:0] set_word;
  logic set_comp, set_write, set_valid;
  logic [4:0] set_tag;
  logic [15:0] set_data;
  logic set_hit, set_dirty, set_valid_out, set_ack;
  logic [4:0] set_tag_out;
  logic [15:0] set_data_out;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic mem_ack;

  always #5 clk = ~clk;

  cache_controller #(.INDEX_W(IW), .WORDS(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
    .set_en(set_en), .set_sel(set_sel), .set_word(set_word), .set_comp(set_comp),
    .set_write(set_write), .set_valid(set_valid), .set_tag(set_tag), .set_data(set_data),
    .set_hit(set_hit), .set_dirty(set_dirty), .set_valid_out(set_valid_out), .set_ack(set_ack),
    .set_tag_out(set_tag_out), .set_data_out(set_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Contents of the external set and memory
  logic        sv [8];
  logic        sd [8];
  logic [4:0]  st [8];
  logic [15:0] sdat [8][4];
  logic [15:0] bmem [1024];

  // Reference model: which line is cached plus the value each address must read back
  logic        rv [8];
  logic        rd [8];
  logic [4:0]  rt [8];
  logic [15:0] rmem [1024];

  logic [10:0] mlog [$];     // {we, addr} of each acknowledged memory access
  logic [10:0] exp_ops [$];
  logic [9:0]  exp_wb [$];
  int fill_cnt = 0;
  int set_dly_fix = -1;
  int mem_dly_fix = -1;
  int dly_max = 5;

  int checks = 0;
  int passed = 0;
  logic exp_pending = 1'b0, exp_hit = 1'b0, exp_we = 1'b0, done_flag = 1'b0;
  logic [15:0] exp_rdata = '0;
  logic p_en = 1'b0, p_mreq = 1'b0;
  logic [28:0] p_scmd = '0;
  logic [26:0] p_mcmd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  // External set: random ack latency, responses and write effects applied at the ack
  initial begin : set_responder
    int cnt;
    int dly;
    int si;
    cnt = 0; dly = 0; si = 0;
    set_ack = 1'b0; set_hit = 1'b0; set_dirty = 1'b0; set_valid_out = 1'b0;
    set_tag_out = '0; set_data_out = '0;
    forever begin
      @(negedge clk);
      if (set_ack) begin
        set_ack = 1'b0;
        cnt = 0;
      end else if (set_en && !rst) begin
        if (cnt == 0) dly = (set_dly_fix >= 0) ? set_dly_fix : int'($urandom_range(0, dly_max));
        if (cnt >= dly) begin
          si = int'(set_sel);
          set_hit       = set_comp && sv[si] && (st[si] == set_tag);
          set_dirty     = sd[si];
          set_valid_out = sv[si];
          set_tag_out   = st[si];
          set_data_out  = sdat[si][set_word];
          if (set_write) begin
            if (set_comp) begin
              if (set_hit) begin
                sdat[si][set_word] = set_data;
                sd[si] = 1'b1;
              end
            end else begin
              sdat[si][set_word] = set_data;
              st[si] = set_tag;
              sv[si] = set_valid;
              sd[si] = 1'b0;
              fill_cnt++;
            end
          end
          set_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Backing memory: random ack latency, every acknowledged access is logged
  initial begin : mem_responder
    int cnt;
    int dly;
    cnt = 0; dly = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req && !rst) begin
        if (cnt == 0) dly = (mem_dly_fix >= 0) ? mem_dly_fix : int'($urandom_range(0, dly_max));
        if (cnt >= dly) begin
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else mem_rdata = bmem[mem_addr];
          mlog.push_back({mem_we, mem_addr});
          mem_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Per-cycle checks: handshake rules every cycle, results at each cpu_done
  task automatic monitor_step();
    logic [28:0] scmd;
    logic [26:0] mcmd;
    int n;
    scmd = {set_sel, set_word, set_comp, set_write, set_valid, set_tag, set_data};
    mcmd = {mem_we, mem_addr, mem_wdata};
    chk("set_mem_overlap", 32'(set_en & mem_req), 32'd0);
    if (set_ack) chk("gap_after_set_ack", 32'(set_en), 32'd0);
    if (set_en && p_en) chk("set_cmd_stable", 32'(scmd), 32'(p_scmd));
    if (mem_req && p_mreq) chk("mem_cmd_stable", 32'(mcmd), 32'(p_mcmd));
    p_en = set_en; p_mreq = mem_req; p_scmd = scmd; p_mcmd = mcmd;
    if (cpu_done) begin
      done_flag = 1'b1;
      if (!exp_pending) begin
        checks++;
        $display("FAIL unexpected_done: got cpu_done=1, required 0 (no request outstanding)");
      end else begin
        chk("done_after_ack", 32'(set_ack), 32'd1);
        chk("cpu_hit", 32'(cpu_hit), 32'(exp_hit));
        if (!exp_we) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
        chk("mem_op_count", 32'(mlog.size()), 32'(exp_ops.size()));
        n = (mlog.size() < exp_ops.size()) ? mlog.size() : exp_ops.size();
        for (int i = 0; i < n; i++) chk("mem_op", 32'(mlog[i]), 32'(exp_ops[i]));
        for (int i = 0; i < exp_wb.size(); i++)
          chk("wb_data", 32'(bmem[exp_wb[i]]), 32'(rmem[exp_wb[i]]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor_step();
  endtask

  // Install a line in the set and in the model; a dirty line being replaced is flushed first
  task automatic preload(input int ix, input logic [4:0] tg, input logic v, input logic d,
                         input logic [15:0] base);
    logic [9:0] a;
    if (rv[ix] && rd[ix])
      for (int k = 0; k < 4; k++) begin
        a = {rt[ix], 3'(ix), 2'(k)};
        bmem[a] = rmem[a];
      end
    sv[ix] = v; sd[ix] = d; st[ix] = tg;
    rv[ix] = v; rd[ix] = v && d; rt[ix] = tg;
    for (int k = 0; k < 4; k++) begin
      a = {tg, 3'(ix), 2'(k)};
      sdat[ix][k] = base + 16'(k);
      if (v) begin
        rmem[a] = base + 16'(k);
        if (!d) bmem[a] = base + 16'(k);
      end
    end
  endtask

  // One CPU request: model update, then drive it and wait for its completion
  task automatic do_req(input logic we, input logic [9:0] addr, input logic [15:0] wd);
    logic [4:0] tg;
    logic [2:0] ix;
    logic h;
    int n;
    tg = addr[9:5];
    ix = addr[4:2];
    exp_ops.delete(); exp_wb.delete(); mlog.delete();
    fill_cnt = 0;
    done_flag = 1'b0;
    h = rv[ix] && (rt[ix] == tg);
    if (!h) begin
      if (rv[ix] && rd[ix])
        for (int k = 0; k < 4; k++) begin
          exp_ops.push_back({1'b1, rt[ix], ix, 2'(k)});
          exp_wb.push_back({rt[ix], ix, 2'(k)});
        end
      for (int k = 0; k < 4; k++) exp_ops.push_back({1'b0, tg, ix, 2'(k)});
      rv[ix] = 1'b1; rt[ix] = tg; rd[ix] = 1'b0;
    end
    if (we) begin
      rmem[addr] = wd;
      rd[ix] = 1'b1;
    end else begin
      exp_rdata = rmem[addr];
    end
    exp_hit = h;
    exp_we = we;
    exp_pending = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    tick();
    // Junk on the request inputs while busy must not disturb the latched request
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 10'($urandom); cpu_wdata = 16'($urandom);
    n = 0;
    while (!done_flag && n < 3000) begin
      tick();
      n++;
    end
    if (!done_flag) begin
      checks++;
      $display("FAIL done_timeout: no cpu_done after %0d cycles, required one", n);
    end
    exp_pending = 1'b0;
    $display("req we=%0d addr=0x%03h wdata=0x%04h -> hit=%0d rdata=0x%04h memops=%0d",
             we, addr, wd, cpu_hit, cpu_rdata, mlog.size());
  endtask

  initial begin : main
    logic [9:0] ra;
    int n;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      bmem[i] = 16'($urandom);
      rmem[i] = bmem[i];
    end
    for (int i = 0; i < 8; i++) begin
      sv[i] = 1'b0; sd[i] = 1'b0; st[i] = '0;
      rv[i] = 1'b0; rd[i] = 1'b0; rt[i] = '0;
      for (int k = 0; k < 4; k++) sdat[i][k] = '0;
    end
    repeat (3) tick();
    chk("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk("rst_cpu_hit", 32'(cpu_hit), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_set_en", 32'(set_en), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    rst = 1'b0;
    tick();

    // Read hit on a preloaded line
    preload(2, 5'h0A, 1'b1, 1'b0, 16'hBEEE);
    do_req(1'b0, {5'h0A, 3'd2, 2'd1}, 16'h0);
    chk("t_hit_rdata", 32'(cpu_rdata), 32'h0000BEEF);
    chk("t_hit_flag", 32'(cpu_hit), 32'd1);
    chk("t_hit_no_mem", 32'(mlog.size()), 32'd0);

    // Clean miss read with memory words 0x1000+k
    preload(0, 5'h00, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      bmem[{5'h03, 3'd0, 2'(k)}] = 16'h1000 + 16'(k);
      rmem[{5'h03, 3'd0, 2'(k)}] = 16'h1000 + 16'(k);
    end
    do_req(1'b0, {5'h03, 3'd0, 2'd3}, 16'h0);
    chk("t_clean_rdata", 32'(cpu_rdata), 32'h00001003);
    chk("t_clean_hit", 32'(cpu_hit), 32'd0);
    chk("t_clean_memrd", 32'(mlog.size()), 32'd4);
    chk("t_clean_fills", 32'(fill_cnt), 32'd4);

    // Dirty miss: victim tag 0x07 written back before any fill read
    preload(1, 5'h07, 1'b1, 1'b1, 16'hA000);
    do_req(1'b0, {5'h11, 3'd1, 2'd0}, 16'h0);
    for (int k = 0; k < 4; k++) begin
      ra = {5'h07, 3'd1, 2'(k)};
      if (mlog.size() > k) chk("t_dirty_wb_addr", 32'(mlog[k]), 32'({1'b1, ra}));
      chk("t_dirty_wb_data", 32'(bmem[ra]), 32'hA000 + 32'(k));
    end

    // Write miss then read back
    preload(3, 5'h00, 1'b0, 1'b0, 16'h0);
    do_req(1'b1, {5'h15, 3'd3, 2'd2}, 16'h1234);
    chk("t_wmiss_dirty", 32'(sd[3]), 32'd1);
    do_req(1'b0, {5'h15, 3'd3, 2'd2}, 16'h0);
    chk("t_wmiss_rdata", 32'(cpu_rdata), 32'h00001234);
    chk("t_wmiss_hit", 32'(cpu_hit), 32'd1);

    // Slow responders: every ack five cycles late
    set_dly_fix = 5; mem_dly_fix = 5;
    preload(4, 5'h02, 1'b1, 1'b1, 16'h4000);
    do_req(1'b0, {5'h1E, 3'd4, 2'd3}, 16'h0);
    do_req(1'b1, {5'h1E, 3'd4, 2'd1}, 16'h5555);
    set_dly_fix = -1; mem_dly_fix = -1;

    // Reset while FILL_RD is on word 2
    preload(5, 5'h00, 1'b0, 1'b0, 16'h0);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {5'h09, 3'd5, 2'd0};
    tick();
    cpu_req = 1'b0;
    n = 0;
    while (!(mem_req && !mem_we && mem_addr[1:0] == 2'd2) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++;
      $display("FAIL reset_setup: fill of word 2 not seen after %0d cycles", n);
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_set_en", 32'(set_en), 32'd0);
    chk("mid_rst_cpu_done", 32'(cpu_done), 32'd0);
    chk("mid_rst_cpu_hit", 32'(cpu_hit), 32'd0);
    chk("mid_rst_rdata", 32'(cpu_rdata), 32'd0);
    rst = 1'b0;
    // The abandoned fill left a half-written line in the external set; clear it
    preload(5, 5'h00, 1'b0, 1'b0, 16'h0);
    do_req(1'b0, {5'h09, 3'd5, 2'd0}, 16'h0);
    chk("post_rst_memrd", 32'(mlog.size()), 32'd4);

    // Random traffic over a small tag range so hits, clean and dirty misses all occur
    for (int i = 0; i < 80; i++) begin
      ra = {5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      do_req(1'($urandom_range(0, 1)), ra, 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have exactly one clock, clk, and reset, rst, which is synchronous and active-high.
REQ-002 Parameters (name, default, meaning) SHALL be: INDEX_W, 3, set-select width; WORDS, 4, words per block; ADDR_W, 5+INDEX_W+2, address width.
REQ-003 Ports (name  direction  width  meaning) SHALL be:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 cpu_req  in  1  request strobe, sampled in IDLE only
 cpu_we  in  1  1=write, 0=read
 cpu_addr  in  ADDR_W  {tag[5], index[INDEX_W], word[2]}
 cpu_wdata  in  16  write data
 cpu_rdata  out  16  read data, valid with cpu_done
 cpu_done  out  1  one-cycle completion pulse
 cpu_hit  out  1  first compare hit, valid with cpu_done
 set_en  out  1  set access strobe, level
 set_sel  out  INDEX_W  target set
 set_word, set_comp, set_write, set_valid  out  2,1,1,1  set command fields
 set_tag, set_data  out  5,16  set tag/data inputs
 set_hit, set_dirty, set_valid_out, set_ack  in  1 each  set responses
 set_tag_out, set_data_out  in  5,16  set tag/data outputs
 mem_req, mem_we  out  1,1  memory strobe (level) and direction
 mem_addr, mem_wdata  out  ADDR_W,16  memory word address and data
 mem_rdata, mem_ack  in  16,1  memory data and completion

Function
REQ-004 FSM states SHALL be IDLE, COMP, GAP, WB_RD, WB_WR, FILL_RD, FILL_WR, DONE.
REQ-005 IDLE: on cpu_req, latch cpu_we/addr/wdata, clear first_cmp_done, go COMP; later cpu_req changes SHALL be ignored until DONE.
REQ-006 Set handshake: set_en high with all set_* command fields stable until set_ack=1; in the cycle after set_ack, set_en=0 for at least one cycle (GAP) before any new set access.
REQ-007 COMP: set_comp=1, set_write=cpu_we, set_tag/set_sel/set_word from the latched address, set_data=cpu_wdata.
REQ-008 COMP ack with set_hit=1 SHALL capture set_data_out (read), record cpu_hit on the first compare only, go DONE.
REQ-009 COMP ack with set_hit=0 SHALL go WB_RD if set_valid_out&set_dirty, else FILL_RD with word counter k=0.
REQ-010 WB_RD: access read (comp=0, write=0) of word k; on ack capture set_tag_out/set_data_out, go WB_WR.
REQ-011 WB_WR: mem_req=1, mem_we=1, mem_addr={captured tag, index, k}, mem_wdata=captured data until mem_ack; then k++ and back to WB_RD via GAP, or after k=WORDS-1 to FILL_RD with k=0.
REQ-012 FILL_RD: mem_req=1, mem_we=0, mem_addr={latched tag, index, k} until mem_ack; capture mem_rdata, go FILL_WR.
REQ-013 FILL_WR: access write (comp=0, write=1, set_valid=1, set_tag=latched tag, set_data=filled word); after ack k++, then FILL_RD, or after k=WORDS-1 back to COMP (retry), via GAP.
REQ-014 The retry compare SHALL hit; the write retry marks the line dirty (write-allocate, write-back).
REQ-015 DONE: cpu_done=1 for exactly one cycle, cpu_rdata held until the next cpu_done, then IDLE.
REQ-016 mem_req and set_en SHALL never be high in the same cycle.
REQ-017 k SHALL be 2 bits and wrap 3->0 only on phase change, never mid-phase.
REQ-018 Hit latency: request in cycle 0, COMP from cycle 1; cpu_done the cycle after set_ack.

Reset
REQ-019 rst SHALL force IDLE, k=0, and set_en, mem_req, cpu_done, cpu_hit=0; cpu_rdata=16'h0000; it overrides any in-flight access, which is abandoned without completion.
REQ-020 After rst the first accepted request SHALL be the first cpu_req seen in IDLE.

Structure
REQ-021 A shared package SHALL hold the state encoding, TAG_W=5, DATA_W=16, WORD_W=2 and the address field slice constants.
REQ-022 The block SHALL be a single FSM module with no sub-modules; set and memory are external.

Verification
REQ-023 Read hit: preload line idx 2, tag 5'h0A, word 1 = 16'hBEEF; read 0x0A,2,1 -> cpu_hit=1, cpu_rdata=16'hBEEF, no mem_req.
REQ-024 Clean miss read: line invalid; read tag 5'h03 idx 0 word 3 with mem returning 16'h1000+k -> 4 mem reads, 4 access writes, cpu_rdata=16'h1003, cpu_hit=0.
REQ-025 Dirty miss: line valid and dirty, tag 5'h07 -> 4 mem writes at {07,idx,0..3} before any fill read.
REQ-026 Write miss: write 16'h1234 -> fill, retry hit, line dirty, subsequent read returns 16'h1234 with cpu_hit=1.
REQ-027 Reset mid-FILL_RD (k=2) -> next cycle IDLE, mem_req=0, set_en=0; next request is served normally.
REQ-028 Slow responders: ack delayed 5 cycles -> command fields stable throughout; set_en low ≥1 cycle between accesses.
